// File: rtl/fp_cvt_dw_iter_if.sv
// rtl/fp_cvt_dw_iter_if.sv - request/response bundle for the int32 to double converter
//
// Purpose: groups the request handshake (in_valid/in_ready, w, signed_ctrl),
// the result handshake (out_valid/out_ready, d) and the busy status.
// Modports:
//   master - requester/consumer side: drives in_valid, w, signed_ctrl, out_ready
//   slave  - converter side: drives in_ready, out_valid, d, busy

interface fp_cvt_dw_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] w;
    logic        signed_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] d;
    logic        busy;

    modport master (
        output in_valid,
        output w,
        output signed_ctrl,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  d,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  w,
        input  signed_ctrl,
        input  out_ready,
        output in_ready,
        output out_valid,
        output d,
        output busy
    );
endinterface

// File: rtl/fp_cvt_dw_iter.sv
// rtl/fp_cvt_dw_iter.sv - iterative int32/uint32 to IEEE-754 double converter
//
// Purpose: converts a 32-bit signed or unsigned integer into a double
// (fcvt.d.w / fcvt.d.wu). The magnitude is normalised by a multi-cycle
// shift loop instead of a priority encoder. Every int32 is exact in double
// precision, so there is no rounding stage.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, aborts any in-flight conversion
//   bus  - slave side of fp_cvt_dw_iter_if:
//          in_valid/in_ready  request handshake (in_ready only in IDLE)
//          w, signed_ctrl     operand, sampled only at accept
//          out_valid/out_ready result handshake, d held until accepted
//          d                  {sign, exp[10:0], frac[51:0]}
//          busy               converter not IDLE
// Parameters:
//   FAST_NORM - 0: shift 1 bit per NORM cycle
//               1: shift 8 bits while the top byte is zero, else 1 bit

module fp_cvt_dw_iter #(
    parameter int FAST_NORM = 0
) (
    input  logic             clk,
    input  logic             rst,
    fp_cvt_dw_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [4:0]  cnt_q;
    logic [63:0] d_q;

    logic        sign_in;
    logic [31:0] mag_in;
    logic        byte_skip;
    logic [10:0] exp_val;

    // Negating 0x80000000 wraps back to 0x80000000, which read as unsigned
    // is exactly the magnitude 2^31 we need.
    assign sign_in = bus.signed_ctrl & bus.w[31];
    assign mag_in  = sign_in ? (~bus.w + 32'd1) : bus.w;

    // Whole-byte skip only while the top byte is empty, so the 1-bit steps
    // afterwards can never shoot past the leading one.
    assign byte_skip = (FAST_NORM != 0) && (mag_q[31:24] == 8'd0);

    // Biased exponent: leading one started at bit (31 - cnt), bias 1023.
    assign exp_val = 11'd1054 - {6'd0, cnt_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= 32'd0;
            cnt_q   <= 5'd0;
            d_q     <= 64'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= sign_in;
                        mag_q  <= mag_in;
                        cnt_q  <= 5'd0;
                        if (bus.w == 32'd0) begin
                            // Zero has no leading one; emit +0.0 directly.
                            d_q     <= 64'd0;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_NORM;
                        end
                    end
                end

                ST_NORM: begin
                    if (mag_q[31]) begin
                        // Implicit one at bit 31 is dropped; the 31 bits
                        // below it are the top of the 52-bit fraction.
                        d_q     <= {sign_q, exp_val, mag_q[30:0], 21'd0};
                        state_q <= ST_DONE;
                    end else if (byte_skip) begin
                        mag_q <= mag_q << 8;
                        cnt_q <= cnt_q + 5'd8;
                    end else begin
                        mag_q <= mag_q << 1;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end

                ST_DONE: begin
                    // Returning to IDLE (not accepting) on the handshake
                    // keeps one dead cycle between output and next accept.
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.d         = d_q;

endmodule

// File: tb/tb_fp_cvt_dw_iter.sv
// tb/tb_fp_cvt_dw_iter.sv - self-checking bench for fp_cvt_dw_iter (both FAST_NORM settings)

module tb_fp_cvt_dw_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus (index 0: FAST_NORM=0, index 1: FAST_NORM=1)
    logic        rst_v       [2];
    logic        in_valid_v  [2];
    logic [31:0] w_v         [2];
    logic        sgn_v       [2];
    logic        out_ready_v [2];

    logic        in_ready_o  [2];
    logic        out_valid_o [2];
    logic [63:0] d_o         [2];
    logic        busy_o      [2];

    fp_cvt_dw_iter_if u_if0 ();
    fp_cvt_dw_iter_if u_if1 ();

    fp_cvt_dw_iter #(.FAST_NORM(0)) u_dut0 (.clk(clk), .rst(rst_v[0]), .bus(u_if0.slave));
    fp_cvt_dw_iter #(.FAST_NORM(1)) u_dut1 (.clk(clk), .rst(rst_v[1]), .bus(u_if1.slave));

    assign u_if0.in_valid    = in_valid_v[0];
    assign u_if0.w           = w_v[0];
    assign u_if0.signed_ctrl = sgn_v[0];
    assign u_if0.out_ready   = out_ready_v[0];
    assign in_ready_o[0]     = u_if0.in_ready;
    assign out_valid_o[0]    = u_if0.out_valid;
    assign d_o[0]            = u_if0.d;
    assign busy_o[0]         = u_if0.busy;

    assign u_if1.in_valid    = in_valid_v[1];
    assign u_if1.w           = w_v[1];
    assign u_if1.signed_ctrl = sgn_v[1];
    assign u_if1.out_ready   = out_ready_v[1];
    assign in_ready_o[1]     = u_if1.in_ready;
    assign out_valid_o[1]    = u_if1.out_valid;
    assign d_o[1]            = u_if1.d;
    assign busy_o[1]         = u_if1.busy;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference result: the integer's value as a real, reinterpreted as bits.
    function automatic logic [63:0] ref_d(input logic [31:0] w, input logic sgn);
        longint v;
        real    r;
        v = sgn ? longint'($signed(w)) : longint'({32'd0, w});
        r = real'(v);
        return $realtobits(r);
    endfunction

    // Reference latency from the leading-zero count of the magnitude.
    function automatic int ref_lat(input logic [31:0] w, input logic sgn, input int fast);
        longint v;
        int     lz;
        v = sgn ? longint'($signed(w)) : longint'({32'd0, w});
        if (v == 0) return 1;
        if (v < 0) v = -v;
        lz = 0;
        while (v < 64'sd2147483648) begin
            v = v * 2;
            lz++;
        end
        return 2 + ((fast != 0) ? (lz / 8 + lz % 8) : lz);
    endfunction

    task automatic wait_idle(input int s, input string tag);
        int n;
        n = 0;
        while (!in_ready_o[s] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/idle"}, 64'(in_ready_o[s]), 64'd1);
    endtask

    task automatic run_conv(input int s, input logic [31:0] w, input logic sgn,
                            input int hold, input string name);
        string       tag;
        logic [63:0] exp_d;
        int          exp_l;
        int          lat;
        tag   = $sformatf("%s/f%0d/w%h/s%0d", name, s, w, sgn);
        exp_d = ref_d(w, sgn);
        exp_l = ref_lat(w, sgn, s);
        wait_idle(s, tag);
        in_valid_v[s] = 1'b1;
        w_v[s]        = w;
        sgn_v[s]      = sgn;
        @(negedge clk);
        // Operand must only matter at accept: scramble it right away.
        in_valid_v[s] = 1'b0;
        w_v[s]        = $urandom;
        sgn_v[s]      = 1'($urandom);
        lat = 1;
        while (!out_valid_o[s] && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/lat"}, 64'(lat), 64'(exp_l));
        check({tag, "/d"}, d_o[s], exp_d);
        check({tag, "/rdy_busy"}, {62'd0, in_ready_o[s], busy_o[s]}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid_v[s] = 1'b1;
            @(negedge clk);
            check({tag, "/hold_d"}, d_o[s], exp_d);
            check({tag, "/hold_v_r"}, {62'd0, out_valid_o[s], in_ready_o[s]}, 64'd2);
        end
        in_valid_v[s]  = 1'b0;
        out_ready_v[s] = 1'b1;
        @(negedge clk);
        out_ready_v[s] = 1'b0;
        check({tag, "/post_v_r"}, {62'd0, out_valid_o[s], in_ready_o[s]}, 64'd1);
    endtask

    task automatic reset_mid(input int s);
        string tag;
        int    stale;
        tag = $sformatf("rst_mid/f%0d", s);
        wait_idle(s, tag);
        in_valid_v[s] = 1'b1;
        w_v[s]        = 32'd1;
        sgn_v[s]      = 1'b0;
        @(negedge clk);
        in_valid_v[s] = 1'b0;
        repeat (3) @(negedge clk);
        rst_v[s] = 1'b1;
        @(negedge clk);
        rst_v[s] = 1'b0;
        check({tag, "/state"}, {d_o[s][61:0], out_valid_o[s], in_ready_o[s]}, 64'd1);
        check({tag, "/busy"}, 64'(busy_o[s]), 64'd0);
        check({tag, "/d"}, d_o[s], 64'd0);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o[s]) stale++;
        end
        check({tag, "/stale"}, 64'(stale), 64'd0);
        run_conv(s, 32'd2, 1'b0, 0, "after_rst");
    endtask

    task automatic run_instance(input int s);
        logic [31:0] w;
        logic        sgn;
        check($sformatf("reset/f%0d/rdy", s), 64'(in_ready_o[s]), 64'd1);
        check($sformatf("reset/f%0d/vld", s), 64'(out_valid_o[s]), 64'd0);
        check($sformatf("reset/f%0d/busy", s), 64'(busy_o[s]), 64'd0);
        check($sformatf("reset/f%0d/d", s), d_o[s], 64'd0);

        run_conv(s, 32'hFFFF_FFFF, 1'b0, 0, "umax");
        run_conv(s, 32'h8000_0000, 1'b1, 0, "smin");
        run_conv(s, 32'hFFFF_FFFF, 1'b1, 1, "sneg1");
        run_conv(s, 32'd5, 1'b1, 0, "s5");
        run_conv(s, 32'd1, 1'b0, 0, "u1");
        run_conv(s, 32'd0, 1'b1, 0, "zero_s");
        run_conv(s, 32'd0, 1'b0, 2, "zero_u");
        run_conv(s, 32'h0012_3456, 1'b0, 5, "bp5");
        run_conv(s, 32'h8000_0000, 1'b0, 0, "u2p31");

        reset_mid(s);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       w = 32'd0;
                1:       w = 32'h8000_0000;
                2:       w = 32'd1 << $urandom_range(0, 31);
                default: w = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 3) == 0) w = ~w;
            sgn = 1'($urandom);
            run_conv(s, w, sgn, $urandom_range(0, 3), "rand");
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_v[s]       = 1'b1;
            in_valid_v[s]  = 1'b0;
            w_v[s]         = 32'd0;
            sgn_v[s]       = 1'b0;
            out_ready_v[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        @(negedge clk);
        run_instance(0);
        run_instance(1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
